// File: rtl/pipe_field.sv
// pipe_field: generates pipe obstacles at the right edge of the LED matrix,
// scrolls them toward the bird column, detects collisions and keeps a
// saturating score. Optional build macro PIPE_FIELD_SPEEDUP_EN shortens the
// scroll period by one cycle each time the score reaches a nonzero multiple
// of four (never below one cycle).
module pipe_field #(
  parameter int ROWS         = 8,
  parameter int COLS         = 8,
  parameter int SCROLL_DIV   = 4,
  parameter int PIPE_SPACING = 4,
  parameter int GAP          = 3,
  parameter int SCORE_W      = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in,
  input  logic [ROWS-1:0]      bird_col,
  output logic [ROWS*COLS-1:0] pipes,
  output logic                 Over,
  output logic [SCORE_W-1:0]   score
);

  localparam int TICK_W    = $clog2(SCROLL_DIV + 1);
  localparam int SP_W      = (PIPE_SPACING > 1) ? $clog2(PIPE_SPACING) : 1;
  localparam int N_GAP_POS = ROWS - GAP + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_OVER = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [ROWS*COLS-1:0]   pipes_q, pipes_d;
  logic [SCORE_W-1:0]     score_q, score_d;
  logic [TICK_W-1:0]      tick_q, tick_d;
  logic [SP_W-1:0]        spacing_q, spacing_d;
  logic [7:0]             lfsr_q, lfsr_d;

  logic [TICK_W-1:0]      tick_last;
  logic [31:0]            gap_pos;
  logic [ROWS-1:0]        spawn_hole;
  logic [ROWS-1:0]        spawn_col;
  logic [ROWS-1:0]        col0;
  logic                   collision;
  logic                   score_inc;

`ifdef PIPE_FIELD_SPEEDUP_EN
  logic [TICK_W-1:0]      period_q, period_d;
  assign tick_last = period_q - TICK_W'(1);
`else
  assign tick_last = TICK_W'(SCROLL_DIV - 1);
`endif

  // Fibonacci LFSR x^8+x^6+x^5+x^4+1; free-running so gaps depend on start time
  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  // Lowest open row of the next pipe, and the open rows it implies
  assign gap_pos = 32'(lfsr_q) % 32'(N_GAP_POS);
  for (genvar gi = 0; gi < ROWS; gi++) begin : g_hole
    assign spawn_hole[gi] = (32'(gi) >= gap_pos) && (32'(gi) < gap_pos + 32'(GAP));
  end

  // A pipe is spawned only on the first scroll of each spacing period
  assign spawn_col = (spacing_q == '0) ? ~spawn_hole : '0;

  assign col0      = pipes_q[ROWS-1:0];
  assign collision = (state_q == S_RUN) && (((col0 & bird_col) != '0) || (bird_col == '0));
  assign score_inc = (col0 != '0) && (score_q != {SCORE_W{1'b1}});

  // Next-state: FSM, scroll timing, pipe shifting/spawning and scoring
  always_comb begin
    state_d   = state_q;
    pipes_d   = pipes_q;
    score_d   = score_q;
    tick_d    = tick_q;
    spacing_d = spacing_q;
`ifdef PIPE_FIELD_SPEEDUP_EN
    period_d  = period_q;
`endif
    case (state_q)
      S_IDLE: begin
        tick_d = '0;
        if (in) state_d = S_RUN;
      end
      S_RUN: begin
        // Collision wins over a scroll falling in the same cycle
        if (collision) begin
          state_d = S_OVER;
        end else if (tick_q == tick_last) begin
          tick_d    = '0;
          pipes_d   = {spawn_col, pipes_q[ROWS*COLS-1:ROWS]};
          spacing_d = (spacing_q == SP_W'(PIPE_SPACING - 1)) ? '0 : spacing_q + SP_W'(1);
          if (score_inc) begin
            score_d = score_q + SCORE_W'(1);
`ifdef PIPE_FIELD_SPEEDUP_EN
            if (((32'(score_q) + 32'd1) % 32'd4 == 32'd0) && (period_q > TICK_W'(1)))
              period_d = period_q - TICK_W'(1);
`endif
          end
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
      S_OVER: begin
        state_d = S_OVER;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pipes_q   <= '0;
      score_q   <= '0;
      tick_q    <= '0;
      spacing_q <= '0;
      lfsr_q    <= 8'hA5;
`ifdef PIPE_FIELD_SPEEDUP_EN
      period_q  <= TICK_W'(SCROLL_DIV);
`endif
    end else begin
      state_q   <= state_d;
      pipes_q   <= pipes_d;
      score_q   <= score_d;
      tick_q    <= tick_d;
      spacing_q <= spacing_d;
      lfsr_q    <= lfsr_d;
`ifdef PIPE_FIELD_SPEEDUP_EN
      period_q  <= period_d;
`endif
    end
  end

  assign pipes = pipes_q;
  assign Over  = (state_q == S_OVER);
  assign score = score_q;

endmodule

// File: tb/tb_pipe_field.sv
// Testbench for pipe_field: behavioural model checked every cycle plus
// directed scenarios with hand-computed expectations, and a second instance
// (SCORE_W=2, PIPE_SPACING=1) for score saturation.
`timescale 1ns/1ps
module tb_pipe_field;

  localparam int SCROLL_DIV   = 4;
  localparam int PIPE_SPACING = 4;
  localparam int SCORE_MAX    = 15;

  logic        clk = 1'b0;
  logic        reset, in;
  logic [7:0]  bird_col;
  logic [63:0] pipes;
  logic        Over;
  logic [3:0]  score;

  logic        reset_s, in_s;
  logic [7:0]  bird_s;
  logic [63:0] pipes_s;
  logic        over_s;
  logic [1:0]  score_s;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  // model state: phase 0=idle 1=run 2=over
  logic [7:0] m_col [8];
  int         m_phase, m_score, m_cyc, m_nscroll, m_per;
  logic [7:0] m_lfsr;

  pipe_field dut (
    .clk(clk), .reset(reset), .in(in), .bird_col(bird_col),
    .pipes(pipes), .Over(Over), .score(score)
  );

  pipe_field #(.SCORE_W(2), .PIPE_SPACING(1)) dut_sat (
    .clk(clk), .reset(reset_s), .in(in_s), .bird_col(bird_s),
    .pipes(pipes_s), .Over(over_s), .score(score_s)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_lit(input string name, input logic [63:0] act, input logic [63:0] exp);
    $display("t=%0t check %s value %h want %h", $time, name, act, exp);
    check(name, act, exp);
  endtask

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic logic [63:0] m_pack();
    logic [63:0] v;
    for (int c = 0; c < 8; c++) v[c*8 +: 8] = m_col[c];
    return v;
  endfunction

  // lowest open row of a pipe column, or row 4 when the column is empty
  function automatic logic [7:0] pick_bird(input logic [7:0] c0);
    if (c0 == 8'h00) return 8'h10;
    for (int r = 0; r < 8; r++) if (!c0[r]) return 8'(1 << r);
    return 8'h10;
  endfunction

  function automatic bit gap_shape_ok(input logic [7:0] c);
    logic [7:0] h;
    for (int g = 0; g < 6; g++) begin
      h = 8'h07 << g;
      if (~c == h) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_scroll();
    logic [7:0] hole;
    if (m_col[0] != 8'h00 && m_score < SCORE_MAX) begin
      m_score++;
`ifdef PIPE_FIELD_SPEEDUP_EN
      if (m_score % 4 == 0 && m_per > 1) m_per--;
`endif
    end
    for (int c = 0; c < 7; c++) m_col[c] = m_col[c+1];
    hole = 8'h07 << (m_lfsr % 8'd6);
    m_col[7] = (m_nscroll % PIPE_SPACING == 0) ? ~hole : 8'h00;
    m_nscroll++;
  endtask

  task automatic model_step();
    if (reset) begin
      m_phase = 0; m_score = 0; m_cyc = 0; m_nscroll = 0;
      m_per = SCROLL_DIV; m_lfsr = 8'hA5;
      for (int c = 0; c < 8; c++) m_col[c] = 8'h00;
    end else begin
      case (m_phase)
        0: if (in) begin m_phase = 1; m_cyc = 0; end
        1: begin
          if (bird_col == 8'h00 || (m_col[0] & bird_col) != 8'h00) begin
            m_phase = 2;
          end else begin
            m_cyc++;
            if (m_cyc == m_per) begin
              m_cyc = 0;
              model_scroll();
            end
          end
        end
        default: ;
      endcase
      m_lfsr = lfsr_step(m_lfsr);
    end
  endtask

  // model advances on every active edge
  initial forever begin
    @(posedge clk);
    model_step();
  end

  // compare DUT against the model on every falling edge
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("model_pipes", pipes, m_pack());
      check("model_over", 64'(Over), 64'(m_phase == 2));
      check("model_score", 64'(score), 64'(m_score));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    logic [63:0] snap_p;
    int snap_s;
    int k, want;

    reset = 1'b1; in = 1'b0; bird_col = 8'h10;
    reset_s = 1'b1; in_s = 1'b0; bird_s = 8'h10;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    reset = 1'b0;

    // idle hold
    repeat (20) @(negedge clk);
    check_lit("idle_pipes", pipes, 64'd0);
    check_lit("idle_over", 64'(Over), 64'd0);
    check_lit("idle_score", 64'(score), 64'd0);

    // start, first pipe, arrival in column 0, first point
    in = 1'b1; @(negedge clk); in = 1'b0;
    for (int n = 1; n <= 36; n++) begin
      bird_col = pick_bird(m_col[0]);
      @(negedge clk);
      if (n == 3)  check_lit("col7_before_spawn", 64'(pipes[63:56]), 64'd0);
      if (n == 4) begin
        check_lit("col7_spawned", 64'(pipes[63:56] != 8'h00), 64'd1);
        check_lit("col7_gap_shape", 64'(gap_shape_ok(pipes[63:56])), 64'd1);
      end
      if (n == 31) check_lit("col0_before_arrival", 64'(pipes[7:0]), 64'd0);
      if (n == 32) check_lit("col0_arrived", 64'(pipes[7:0] != 8'h00), 64'd1);
      if (n == 35) check_lit("score_before_pass", 64'(score), 64'd0);
      if (n == 36) begin
        check_lit("score_after_pass", 64'(score), 64'd1);
        check_lit("over_after_pass", 64'(Over), 64'd0);
      end
    end

    // keep passing gaps until score 5
    cnt = 0;
    while (m_score < 5 && cnt < 400) begin
      bird_col = pick_bird(m_col[0]);
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 400) begin
      n_checks++; n_errors++;
      $display("FAIL timeout_score5: score %0d required 5", score);
    end
    check_lit("score_reached_5", 64'(score), 64'd5);

    // collision against a solid row of the next pipe in column 0
    cnt = 0;
    while (m_col[0] == 8'h00 && cnt < 100) begin
      bird_col = pick_bird(m_col[0]);
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 100) begin
      n_checks++; n_errors++;
      $display("FAIL timeout_pipe_col0: col0 %h required nonzero", pipes[7:0]);
    end
    bird_col = m_col[0][0] ? 8'h01 : 8'h80;
    @(negedge clk);
    check_lit("over_after_hit", 64'(Over), 64'd1);
    snap_p = m_pack();
    snap_s = m_score;
    for (int i = 0; i < 20; i++) begin
      in = (i % 5 == 0);
      @(negedge clk);
    end
    in = 1'b0;
    check_lit("frozen_pipes", pipes, snap_p);
    check_lit("frozen_score", 64'(score), 64'(snap_s));
    check_lit("over_held", 64'(Over), 64'd1);

    // reset in OVER
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    check_lit("rst_over_pipes", pipes, 64'd0);
    check_lit("rst_over_over", 64'(Over), 64'd0);
    check_lit("rst_over_score", 64'(score), 64'd0);

    // fall-out
    bird_col = 8'h10;
    in = 1'b1; @(negedge clk); in = 1'b0;
    repeat (5) @(negedge clk);
    check_lit("over_before_fall", 64'(Over), 64'd0);
    bird_col = 8'h00;
    @(negedge clk);
    check_lit("over_after_fall", 64'(Over), 64'd1);
    bird_col = 8'h10;
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    check_lit("rst_fall_pipes", pipes, 64'd0);
    check_lit("rst_fall_over", 64'(Over), 64'd0);

    // saturation on the SCORE_W=2, PIPE_SPACING=1 instance
    reset_s = 1'b0; @(negedge clk);
    in_s = 1'b1; @(negedge clk); in_s = 1'b0;
    for (int n = 1; n <= 52; n++) begin
      bird_s = pick_bird(pipes_s[7:0]);
      @(negedge clk);
      if (n % 4 == 0 && n >= 32) begin
        k = n / 4;
        want = (k - 8 > 3) ? 3 : k - 8;
        check_lit($sformatf("sat_score_scroll%0d", k), 64'(score_s), 64'(want));
        check_lit($sformatf("sat_over_scroll%0d", k), 64'(over_s), 64'd0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
